// File: rtl/isp_arith_pkg.sv
// isp_arith_pkg: arithmetic constants and width helpers shared by the isp_lite
// multiplier and divider.
package isp_arith_pkg;

    localparam int DEFAULT_DIV_BITS = 22;

    function automatic int prod_w(input int bits);
        return 2 * bits;
    endfunction

endpackage

// File: rtl/shift_mul_add_stage.sv
// shift_mul_add_stage: one shift-add step, consuming the low bit of the
// remaining multiplier; data registers load only on a valid input.
module shift_mul_add_stage
    import isp_arith_pkg::*;
#(
    parameter int BITS = DEFAULT_DIV_BITS,
    parameter int W    = prod_w(BITS)
) (
    input  logic            xclk,
    input  logic            reset,
    input  logic            v_in,
    input  logic [W-1:0]    acc_in,
    input  logic [W-1:0]    mcand_in,
    input  logic [BITS-1:0] mplr_in,
    output logic            v_out,
    output logic [W-1:0]    acc_out,
    output logic [W-1:0]    mcand_out,
    output logic [BITS-1:0] mplr_out
);

    logic            v_q, v_d;
    logic [W-1:0]    acc_q, acc_d, mcand_q, mcand_d;
    logic [BITS-1:0] mplr_q, mplr_d;

    always_comb begin
        v_d     = v_in;
        acc_d   = v_in ? acc_in + (mplr_in[0] ? mcand_in : '0) : acc_q;
        mcand_d = v_in ? mcand_in << 1 : mcand_q;
        mplr_d  = v_in ? mplr_in >> 1 : mplr_q;
    end

    always_ff @(posedge xclk) begin
        if (reset) begin
            v_q     <= 1'b0;
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
        end else begin
            v_q     <= v_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
        end
    end

    assign v_out     = v_q;
    assign acc_out   = acc_q;
    assign mcand_out = mcand_q;
    assign mplr_out  = mplr_q;

endmodule

// File: rtl/shift_mul_add_uint.sv
// shift_mul_add_uint: pipelined unsigned prod = a*b + c, one multiplier bit per stage.
// Define SHIFT_MUL_ADD_SAT_EN to clamp prod to 2^BITS-1 on overflow.
module shift_mul_add_uint
    import isp_arith_pkg::*;
#(
    parameter int BITS = DEFAULT_DIV_BITS
) (
    input  logic                    xclk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [BITS-1:0]         a,
    input  logic [BITS-1:0]         b,
    input  logic [BITS-1:0]         c,
    output logic                    out_valid,
    output logic [prod_w(BITS)-1:0] prod,
    output logic                    ovf
);

    localparam int W = prod_w(BITS);

    logic [BITS:0]   v;
    logic [W-1:0]    acc   [0:BITS];
    logic [W-1:0]    mcand [0:BITS];
    logic [BITS-1:0] mplr  [0:BITS];

    // Seeding the accumulator with c lets every stage share one equation.
    assign v[0]     = in_valid;
    assign acc[0]   = {{BITS{1'b0}}, c};
    assign mcand[0] = {{BITS{1'b0}}, a};
    assign mplr[0]  = b;

    for (genvar k = 0; k < BITS; k++) begin : g_stage
        shift_mul_add_stage #(.BITS(BITS), .W(W)) u_stage (
            .xclk      (xclk),
            .reset     (reset),
            .v_in      (v[k]),
            .acc_in    (acc[k]),
            .mcand_in  (mcand[k]),
            .mplr_in   (mplr[k]),
            .v_out     (v[k+1]),
            .acc_out   (acc[k+1]),
            .mcand_out (mcand[k+1]),
            .mplr_out  (mplr[k+1])
        );
    end

    assign out_valid = v[BITS];
    assign ovf       = |acc[BITS][W-1:BITS];
`ifdef SHIFT_MUL_ADD_SAT_EN
    assign prod = ovf ? {{BITS{1'b0}}, {BITS{1'b1}}} : acc[BITS];
`else
    assign prod = acc[BITS];
`endif

endmodule

// File: tb/tb_shift_mul_add_uint.sv
// tb_shift_mul_add_uint: directed vectors with hand-computed results for the
// 22-bit shift-add multiply-accumulate pipeline.
module tb_shift_mul_add_uint;

    logic        xclk = 1'b0;
    logic        reset, in_valid;
    logic [21:0] a, b, c;
    logic        out_valid, ovf;
    logic [43:0] prod;
    int          checks = 0;
    int          errors = 0;

    shift_mul_add_uint #(.BITS(22)) dut (
        .xclk      (xclk),
        .reset     (reset),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .prod      (prod),
        .ovf       (ovf)
    );

    always #5 xclk = ~xclk;

    task automatic tick();
        @(posedge xclk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [21:0] ai, bi, ci);
        in_valid = v;
        a = ai;
        b = bi;
        c = ci;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, '0, '0, '0);
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || prod !== 44'd0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset: out_valid=%b prod=%0d ovf=%b, want 0 0 0", out_valid, prod, ovf);
        end
    endtask

    task automatic test_single(input string name, input logic [21:0] ai, bi, ci,
                               input logic [43:0] exp_p, input logic exp_o);
        int early = 0;
        drive(1'b1, ai, bi, ci);
        tick();
        drive(1'b0, '0, '0, '0);
        if (out_valid !== 1'b0) early++;
        for (int n = 2; n <= 21; n++) begin
            tick();
            if (out_valid !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL %s_latency: out_valid high %0d cycles early, want 0", name, early);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid: out_valid=%b at cycle 22, want 1", name, out_valid);
        end
        checks++;
        if (prod !== exp_p) begin
            errors++;
            $display("FAIL %s_prod: got %0d want %0d", name, prod, exp_p);
        end
        checks++;
        if (ovf !== exp_o) begin
            errors++;
            $display("FAIL %s_ovf: got %b want %b", name, ovf, exp_o);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_single_pulse: out_valid=%b after result, want 0", name, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [21:0] va [4];
        logic [21:0] vb [4];
        logic [21:0] vc [4];
        logic [43:0] vp [4];
        int early = 0;
        va = '{22'd102300, 22'd1, 22'd0, 22'd452};
        vb = '{22'd41, 22'd41, 22'd443, 22'd1};
        vc = '{22'd3, 22'd0, 22'd0, 22'd0};
        vp = '{44'd4194303, 44'd41, 44'd0, 44'd452};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, va[i], vb[i], vc[i]);
            tick();
            if (out_valid !== 1'b0) early++;
        end
        drive(1'b0, '0, '0, '0);
        for (int n = 5; n <= 21; n++) begin
            tick();
            if (out_valid !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL b2b_latency: out_valid high %0d cycles early, want 0", early);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || prod !== vp[i] || ovf !== 1'b0) begin
                errors++;
                $display("FAIL b2b_%0d: out_valid=%b prod=%0d ovf=%b, want 1 %0d 0",
                         i, out_valid, prod, ovf, vp[i]);
            end
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_bubble();
        logic        ev [4];
        logic [43:0] ep [4];
        ev = '{1'b1, 1'b0, 1'b0, 1'b1};
        ep = '{44'd9, 44'd9, 44'd9, 44'd439};
        drive(1'b1, 22'd2, 22'd4, 22'd1);
        tick();
        drive(1'b0, 22'd7, 22'd7, 22'd7);
        tick();
        tick();
        drive(1'b1, 22'd15, 22'd28, 22'd19);
        tick();
        drive(1'b0, '0, '0, '0);
        for (int n = 5; n <= 21; n++) tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out_valid !== ev[i] || prod !== ep[i]) begin
                errors++;
                $display("FAIL bubble_%0d: out_valid=%b prod=%0d, want %b %0d",
                         i, out_valid, prod, ev[i], ep[i]);
            end
        end
    endtask

    task automatic test_reset_mid_pipe();
        int leaks = 0;
        for (int n = 1; n <= 5; n++) begin
            drive(1'b1, 22'd2, 22'd4, 22'd1);
            tick();
        end
        drive(1'b0, '0, '0, '0);
        for (int n = 6; n <= 9; n++) tick();
        reset = 1'b1;
        drive(1'b1, 22'd2, 22'd4, 22'd1);
        tick();
        reset = 1'b0;
        drive(1'b0, '0, '0, '0);
        checks++;
        if (out_valid !== 1'b0 || prod !== 44'd0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL midreset_clear: out_valid=%b prod=%0d ovf=%b, want 0 0 0", out_valid, prod, ovf);
        end
        for (int n = 1; n <= 22; n++) begin
            tick();
            if (out_valid !== 1'b0 || prod !== 44'd0) leaks++;
        end
        checks++;
        if (leaks != 0) begin
            errors++;
            $display("FAIL midreset_flush: %0d cycles with output activity, want 0", leaks);
        end
    endtask

    initial begin
        test_reset();
        test_single("single_9", 22'd2, 22'd4, 22'd1, 44'd9, 1'b0);
        test_single("single_439", 22'd15, 22'd28, 22'd19, 44'd439, 1'b0);
        test_back_to_back();
`ifdef SHIFT_MUL_ADD_SAT_EN
        test_single("max", 22'h3FFFFF, 22'h3FFFFF, 22'h3FFFFF, 44'd4194303, 1'b1);
`else
        test_single("max", 22'h3FFFFF, 22'h3FFFFF, 22'h3FFFFF, 44'hFFFFFC00000, 1'b1);
`endif
        test_bubble();
        test_reset_mid_pipe();
        test_single("post_reset", 22'd15, 22'd28, 22'd19, 44'd439, 1'b0);
        test_single("zero_mplr", 22'd4194303, 22'd0, 22'd4532, 44'd4532, 1'b0);
        test_single("zero_mcand", 22'd0, 22'd123456, 22'd77, 44'd77, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
